uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  - UART receiver top: oversamples async serial line `data`, deserializes one frame
//    (start, 8 data LSB-first, optional parity, 1 stop), flags good byte with one-cycle data_valid.
//  - Sits between the pad/line synchronizer and byte-level consumer; configuration is runtime ports.
// PARAMETERS
//  - DATA_WIDTH  8  data bits per frame (only 8 required)
//  - PRESC_WIDTH 8  width of prescale port
// PORTS
//  - clk         in   1  oversampling clock (prescale clocks per bit)
//  - rst         in   1  reset; one clock; reset is asynchronous and active-low
//  - data        in   1  serial line, idle high
//  - par_enable  in   1  1 = parity bit present after data bits
//  - par_type    in   1  0 = even parity, 1 = odd parity
//  - prescale    in   8  clocks per bit; legal: even values 4..32 (4,8,16,32 verified)
//  - data_out    out  8  last received byte, bit0 = first data bit on line
//  - data_valid  out  1  one-cycle pulse: data_out holds a frame that passed all checks
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE, counters=0, data_out=8'h00, data_valid=0.
//  - Config (par_enable, par_type, prescale) latched when leaving IDLE; changes mid-frame ignored.
//  - Edge counter 0..prescale-1 per bit; bit counter advances when edge counter wraps.
//  - Sampling: line sampled at edge counts prescale/2-1, prescale/2, prescale/2+1;
//    bit value = majority of the 3 samples (prescale=4 -> counts 1,2,3).
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   data==0 on a clk edge -> START, edge counter=0 in that cycle.
//    START:  at edge prescale-1: voted bit 0 -> DATA; voted 1 (glitch) -> IDLE, no output.
//    DATA:   8 bits shifted in LSB-first; after bit 7 -> PARITY if par_enable else STOP.
//    PARITY: voted bit compared to XOR(data) (even) / ~XOR(data) (odd); error flag latched.
//    STOP:   at edge prescale-1: voted 1 and no parity error -> data_out<=byte, data_valid=1
//            for exactly that one cycle; always -> IDLE next cycle.
//  - Frame length: (10 + par_enable) * prescale clocks from start edge to data_valid edge.
//  - Errors (parity mismatch, stop bit 0): no data_valid, data_out keeps previous value,
//    FSM -> IDLE; a low line is then treated as a new start bit.
//  - Back-to-back frames: start bit detected from IDLE on the cycle after STOP ends.
//  - data_out changes only together with a data_valid pulse.
//  - Reset asserted mid-frame: immediate abort, outputs to reset values, no pulse.
// STRUCTURE
//  - Shared package uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP), DATA_WIDTH,
//    PAR_EVEN=0/PAR_ODD=1 constants.
//  - One natural sub-module: uart_rx_sampler (edge counter + 3-sample majority vote,
//    outputs sampled_bit and bit_done strobe); FSM, shift register, checks in top.
// TESTING (clk 10 ns, prescale=4 -> 40 ns/bit, line idle 1, rst released with start bit)
//  - No parity: bits 0|0,1,0,0,1,0,1,1|1 -> data_out=8'hD2, data_valid 1 cycle, 40 clks after start.
//  - Even parity: 0|0,1,0,0,1,0,1,1|0|1 (par_enable=1,par_type=0) -> 8'hD2, data_valid pulse.
//  - Odd parity: same byte, parity bit 1 (par_type=1) -> 8'hD2; parity bit 0 -> no pulse.
//  - Stop bit 0 (no parity, byte 8'hA5) -> no data_valid, data_out unchanged, FSM back to IDLE.
//  - Start glitch: line low 1 clk then high -> no frame, next real frame 8'h3C received normally.
//  - prescale=8, two back-to-back frames 8'h55 then 8'hAA -> two pulses, 80 clks apart;
//    rst pulsed mid-frame -> data_out=0, data_valid=0, next frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Value the parity bit must carry for the given data byte and parity mode.
    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] bits,
                                             input logic                  par_type);
        logic par;
        case (par_type)
            PAR_EVEN: par = ^bits;
            PAR_ODD:  par = ~(^bits);
            default:  par = ^bits;
        endcase
        return par;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a three-tap majority vote around the bit centre.
module uart_rx_sampler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data,
    input  logic                   start,
    input  logic                   run,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   sampled_bit,
    output logic                   bit_done
);

    logic [PRESC_WIDTH-1:0] edge_cnt_reg;
    logic [PRESC_WIDTH-1:0] edge_cnt_next;
    logic [PRESC_WIDTH-1:0] half;
    logic [2:0]             tap_hit;
    logic [2:0]             samples_reg;
    logic [2:0]             votes;

    assign half = prescale >> 1;

    // Taps sit at half-1, half and half+1 within the bit.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap
            assign tap_hit[gi] = run &&
                (edge_cnt_reg == half + PRESC_WIDTH'(gi) - PRESC_WIDTH'(1));
        end
    endgenerate

    assign bit_done = run && (edge_cnt_reg == prescale - PRESC_WIDTH'(1));

    // The detecting IDLE cycle is count 0 of the start bit, so START begins at 1.
    always_comb begin
        edge_cnt_next = '0;
        if (start) begin
            edge_cnt_next = PRESC_WIDTH'(1);
        end else if (run) begin
            edge_cnt_next = bit_done ? '0 : edge_cnt_reg + PRESC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_reg <= '0;
            samples_reg  <= '0;
        end else begin
            edge_cnt_reg <= edge_cnt_next;
            for (int i = 0; i < 3; i++) begin
                if (tap_hit[i]) begin
                    samples_reg[i] <= data;
                end
            end
        end
    end

    // At the smallest prescale the last tap coincides with bit_done, so use the live line.
    assign votes       = {tap_hit[2] ? data : samples_reg[2], samples_reg[1:0]};
    assign sampled_bit = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, 8 data bits LSB first, optional parity, one stop bit.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data,
    input  logic                   par_enable,
    input  logic                   par_type,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid
);

    import uart_pkg::*;

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

    rx_state_t               state_reg;
    rx_state_t               state_next;
    logic                    par_en_reg;
    logic                    par_type_reg;
    logic [PRESC_WIDTH-1:0]  presc_reg;
    logic [BIT_CNT_W-1:0]    bit_cnt_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_err_reg;
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic                    data_valid_reg;

    logic                    start_det;
    logic                    run;
    logic                    sampled_bit;
    logic                    bit_done;
    logic                    frame_ok;

    assign start_det = (state_reg == IDLE) && !data;
    assign run       = (state_reg != IDLE);

    uart_rx_sampler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .start       (start_det),
        .run         (run),
        .prescale    (presc_reg),
        .sampled_bit (sampled_bit),
        .bit_done    (bit_done)
    );

    always_comb begin
        state_next = state_reg;
        frame_ok   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!data) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that votes high was a glitch.
                if (bit_done) begin
                    state_next = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_cnt_reg == BIT_CNT_W'(DATA_WIDTH - 1))) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                    frame_ok   = sampled_bit && !par_err_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            par_en_reg     <= 1'b0;
            par_type_reg   <= 1'b0;
            presc_reg      <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            par_err_reg    <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            data_valid_reg <= 1'b0;

            // Configuration is frozen for the whole frame.
            if (start_det) begin
                par_en_reg   <= par_enable;
                par_type_reg <= par_type;
                presc_reg    <= prescale;
                bit_cnt_reg  <= '0;
                par_err_reg  <= 1'b0;
            end

            if (bit_done) begin
                case (state_reg)
                    DATA: begin
                        shift_reg   <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
                    end
                    PARITY: begin
                        par_err_reg <= (sampled_bit != expected_parity(shift_reg, par_type_reg));
                    end
                    default: begin
                    end
                endcase
            end

            if (frame_ok) begin
                data_out_reg   <= shift_reg;
                data_valid_reg <= 1'b1;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames vs. a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data = 1'b1;
    logic       par_enable = 1'b0;
    logic       par_type = 1'b0;
    logic [7:0] prescale = 8'd4;
    logic [7:0] data_out;
    logic       data_valid;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         stray = 0;
    logic [7:0] prev_dout = 8'h00;
    logic [7:0] model_dout = 8'h00;
    logic [7:0] pulse_data[$];
    int         pulse_cyc[$];

    uart_rx #(
        .DATA_WIDTH  (8),
        .PRESC_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .par_enable (par_enable),
        .par_type   (par_type),
        .prescale   (prescale),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every pulse and any data_out change that is not accompanied by one.
    always @(negedge clk) begin
        if (rst && data_valid) begin
            pulse_data.push_back(data_out);
            pulse_cyc.push_back(cyc);
        end
        if (rst && !data_valid && (data_out !== prev_dout)) stray++;
        prev_dout = data_out;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_pulses();
        pulse_data.delete();
        pulse_cyc.delete();
    endtask

    task automatic line_idle(input int n);
        @(posedge clk);
        #1 data = 1'b1;
        repeat (n - 1) @(posedge clk);
    endtask

    // Drives one frame; optionally scrambles the config inputs after the start bit.
    task automatic send_frame(input logic [7:0] b, input bit pe, input bit pbit,
                              input bit stop, input int p, input bit scramble,
                              output int start_cyc);
        logic fbits[11];
        int   n;
        fbits[0] = 1'b0;
        for (int k = 0; k < 8; k++) fbits[k + 1] = b[k];
        if (pe) begin
            fbits[9]  = pbit;
            fbits[10] = stop;
        end else begin
            fbits[9]  = stop;
            fbits[10] = 1'b1;
        end
        n = pe ? 11 : 10;
        start_cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 data = fbits[i];
            if (i == 0) start_cyc = cyc;
            if (i == 1 && scramble) begin
                par_type   = ~par_type;
                par_enable = ~par_enable;
                prescale   = (p == 4) ? 8'd8 : 8'd4;
            end
            repeat (p - 1) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data_out: got %h expected 00", data_out);
        end
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data_valid: got %b expected 0", data_valid);
        end
        rst = 1'b1;
        $display("reset released: data_out=%h data_valid=%b", data_out, data_valid);
    endtask

    task automatic test_no_parity();
        int t0;
        clear_pulses();
        par_enable = 1'b0; par_type = 1'b0; prescale = 8'd4;
        send_frame(8'hD2, 0, 0, 1, 4, 0, t0);
        line_idle(6);
        n_cmp++;
        if (pulse_data.size() !== 1) begin
            n_bad++;
            $display("FAIL no_parity_pulses: got %0d expected 1", pulse_data.size());
        end else begin
            n_cmp++;
            if (pulse_data[0] !== 8'hD2) begin
                n_bad++;
                $display("FAIL no_parity_data: got %h expected d2", pulse_data[0]);
            end
            n_cmp++;
            if (pulse_cyc[0] - t0 !== 40) begin
                n_bad++;
                $display("FAIL no_parity_latency: got %0d expected 40", pulse_cyc[0] - t0);
            end
        end
        model_dout = 8'hD2;
        $display("frame no-parity byte d2: pulses=%0d data_out=%h", pulse_data.size(), data_out);
    endtask

    task automatic test_even_parity();
        int t0;
        clear_pulses();
        par_enable = 1'b1; par_type = 1'b0; prescale = 8'd4;
        send_frame(8'hD2, 1, 0, 1, 4, 0, t0);
        line_idle(6);
        n_cmp++;
        if (pulse_data.size() !== 1) begin
            n_bad++;
            $display("FAIL even_parity_pulses: got %0d expected 1", pulse_data.size());
        end else begin
            n_cmp++;
            if (pulse_data[0] !== 8'hD2 || pulse_cyc[0] - t0 !== 44) begin
                n_bad++;
                $display("FAIL even_parity_frame: got %h after %0d expected d2 after 44",
                         pulse_data[0], pulse_cyc[0] - t0);
            end
        end
        $display("frame even-parity byte d2: pulses=%0d data_out=%h", pulse_data.size(), data_out);
    endtask

    task automatic test_odd_parity();
        int t0;
        clear_pulses();
        par_enable = 1'b1; par_type = 1'b1; prescale = 8'd4;
        send_frame(8'hD2, 1, 1, 1, 4, 0, t0);
        line_idle(6);
        n_cmp++;
        if (pulse_data.size() !== 1 || pulse_data[0] !== 8'hD2) begin
            n_bad++;
            $display("FAIL odd_parity_good: got %0d pulses expected 1 pulse of d2", pulse_data.size());
        end
        $display("frame odd-parity byte d2 pbit 1: pulses=%0d", pulse_data.size());
        clear_pulses();
        send_frame(8'hD2, 1, 0, 1, 4, 0, t0);
        line_idle(6);
        n_cmp++;
        if (pulse_data.size() !== 0) begin
            n_bad++;
            $display("FAIL odd_parity_bad: got %0d pulses expected 0", pulse_data.size());
        end
        n_cmp++;
        if (data_out !== model_dout) begin
            n_bad++;
            $display("FAIL odd_parity_bad_hold: got %h expected %h", data_out, model_dout);
        end
        $display("frame odd-parity byte d2 pbit 0: pulses=%0d data_out=%h", pulse_data.size(), data_out);
    endtask

    task automatic test_stop_error();
        int t0;
        clear_pulses();
        par_enable = 1'b0; par_type = 1'b0; prescale = 8'd4;
        send_frame(8'hA5, 0, 0, 0, 4, 0, t0);
        line_idle(8);
        n_cmp++;
        if (pulse_data.size() !== 0) begin
            n_bad++;
            $display("FAIL stop_error_pulses: got %0d expected 0", pulse_data.size());
        end
        n_cmp++;
        if (data_out !== model_dout) begin
            n_bad++;
            $display("FAIL stop_error_hold: got %h expected %h", data_out, model_dout);
        end
        $display("frame stop-error byte a5: pulses=%0d data_out=%h", pulse_data.size(), data_out);
    endtask

    task automatic test_start_glitch();
        int t0;
        clear_pulses();
        par_enable = 1'b0; prescale = 8'd4;
        @(posedge clk);
        #1 data = 1'b0;
        line_idle(12);
        n_cmp++;
        if (pulse_data.size() !== 0) begin
            n_bad++;
            $display("FAIL glitch_pulses: got %0d expected 0", pulse_data.size());
        end
        send_frame(8'h3C, 0, 0, 1, 4, 0, t0);
        line_idle(6);
        n_cmp++;
        if (pulse_data.size() !== 1) begin
            n_bad++;
            $display("FAIL glitch_next_pulses: got %0d expected 1", pulse_data.size());
        end else begin
            n_cmp++;
            if (pulse_data[0] !== 8'h3C || pulse_cyc[0] - t0 !== 40) begin
                n_bad++;
                $display("FAIL glitch_next_frame: got %h after %0d expected 3c after 40",
                         pulse_data[0], pulse_cyc[0] - t0);
            end
        end
        model_dout = 8'h3C;
        $display("frame after glitch byte 3c: pulses=%0d data_out=%h", pulse_data.size(), data_out);
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        clear_pulses();
        par_enable = 1'b0; prescale = 8'd8;
        send_frame(8'h55, 0, 0, 1, 8, 0, t0);
        send_frame(8'hAA, 0, 0, 1, 8, 0, t1);
        line_idle(6);
        n_cmp++;
        if (pulse_data.size() !== 2) begin
            n_bad++;
            $display("FAIL b2b_pulses: got %0d expected 2", pulse_data.size());
        end else begin
            n_cmp++;
            if (pulse_data[0] !== 8'h55 || pulse_data[1] !== 8'hAA) begin
                n_bad++;
                $display("FAIL b2b_data: got %h %h expected 55 aa", pulse_data[0], pulse_data[1]);
            end
            n_cmp++;
            if (pulse_cyc[1] - pulse_cyc[0] !== 80 || pulse_cyc[0] - t0 !== 80) begin
                n_bad++;
                $display("FAIL b2b_spacing: got gap %0d latency %0d expected 80 80",
                         pulse_cyc[1] - pulse_cyc[0], pulse_cyc[0] - t0);
            end
        end
        model_dout = 8'hAA;
        $display("frames back-to-back 55 aa: pulses=%0d data_out=%h", pulse_data.size(), data_out);
    endtask

    task automatic test_mid_reset();
        int t0;
        clear_pulses();
        par_enable = 1'b0; prescale = 8'd8;
        @(posedge clk);
        #1 data = 1'b0;
        repeat (7) @(posedge clk);
        #1 data = 1'b1;
        repeat (12) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (data_out !== 8'h00 || data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h/%b expected 00/0", data_out, data_valid);
        end
        model_dout = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        line_idle(90);
        n_cmp++;
        if (pulse_data.size() !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_abort: got %0d pulses expected 0", pulse_data.size());
        end
        send_frame(8'h96, 0, 0, 1, 8, 0, t0);
        line_idle(6);
        n_cmp++;
        if (pulse_data.size() !== 1 || pulse_data[0] !== 8'h96) begin
            n_bad++;
            $display("FAIL mid_reset_next: got %0d pulses expected 1 pulse of 96", pulse_data.size());
        end
        model_dout = 8'h96;
        $display("frame after mid-frame reset byte 96: pulses=%0d data_out=%h", pulse_data.size(), data_out);
    endtask

    task automatic test_random();
        int         t0;
        logic [7:0] b;
        bit         pe, pt, pbit, stop, scr, exp_valid;
        int         p;
        for (int f = 0; f < 16; f++) begin
            b    = 8'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            p    = 4 << $urandom_range(0, 3);
            scr  = 1'($urandom);
            pbit = (^b) ^ pt ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 5) != 0);
            exp_valid = stop && (!pe || pbit == ((^b) ^ pt));
            clear_pulses();
            par_enable = pe; par_type = pt; prescale = 8'(p);
            send_frame(b, pe, pbit, stop, p, scr, t0);
            line_idle($urandom_range(3, 7));
            if (exp_valid) model_dout = b;
            n_cmp++;
            if (pulse_data.size() !== (exp_valid ? 1 : 0)) begin
                n_bad++;
                $display("FAIL rand%0d_pulses: got %0d expected %0d", f, pulse_data.size(), exp_valid);
            end else if (exp_valid) begin
                n_cmp++;
                if (pulse_cyc[0] - t0 !== (pe ? 11 : 10) * p) begin
                    n_bad++;
                    $display("FAIL rand%0d_latency: got %0d expected %0d", f,
                             pulse_cyc[0] - t0, (pe ? 11 : 10) * p);
                end
            end
            n_cmp++;
            if (data_out !== model_dout) begin
                n_bad++;
                $display("FAIL rand%0d_data_out: got %h expected %h", f, data_out, model_dout);
            end
            $display("rand frame %0d: byte %h pe=%0d pt=%0d pbit=%0d stop=%0d p=%0d scr=%0d -> pulses=%0d data_out=%h",
                     f, b, pe, pt, pbit, stop, p, scr, pulse_data.size(), data_out);
        end
    endtask

    task automatic test_data_out_stable();
        n_cmp++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL data_out_stable: got %0d changes without pulse expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_stop_error();
        test_start_glitch();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_data_out_stable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
